controle_entrada_saida: RTL and testbench
=========================================

Name: controle_entrada_saida

Overview:
- Peripheral-side responder to the decoder's congela_in/congela_out requests.
- Stalls the datapath while an IN instruction waits for a debounced operator confirm, then returns the switch value for register write-back.
- For OUT, latches the register value into the display register and holds the stall for a fixed display time.
- Sits between the control unit, PC/register-file write enables, and the board switches, button and display.

Parameters:
- LARGURA_SW, 16, switch bus width (must be at most 32).
- DEBOUNCE_CICLOS, 500000, consecutive stable samples needed to accept a button level.
- OUT_CICLOS, 50000000, cycles the stall is held after an OUT latch.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- congela_in  in  1  IN instruction pending (from control unit).
- congela_out  in  1  OUT instruction pending (from control unit).
- chaves  in  LARGURA_SW  board switches; asynchronous, quasi-static.
- botao  in  1  raw confirm button, active-high, asynchronous.
- dado_out  in  32  register value to display.
- congela  out  1  stall to PC/pipeline; 1 = hold.
- dado_in  out  32  captured switch value, zero-extended, for the write-back mux.
- in_valido  out  1  one-cycle pulse; write-back of dado_in happens on this cycle's edge.
- display  out  32  value shown on the display.
- aguardando_in  out  1  LED: waiting for operator.

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous active-high. All flops clear on reset.
- Reset values: state=OCIOSO, dado_in=0, display=0, in_valido=0, aguardando_in=0, debounce counter=0, display counter=0.
- congela is combinational: (congela_in | congela_out) & ~libera. libera=1 only in states IN_FIM and OUT_FIM.
  - congela therefore rises in the same cycle the opcode is decoded; there is zero added latency.
- Button path: 2-flop synchronizer, then the debounce sub-module. botao_estavel changes only after DEBOUNCE_CICLOS consecutive identical synchronized samples. A mismatch restarts the count.
- FSM states: OCIOSO, IN_ESPERA_PRESS, IN_ESPERA_SOLTA, IN_FIM, OUT_CONTA, OUT_FIM.
- OCIOSO:
  - If congela_in=1, go to IN_ESPERA_PRESS.
  - Else if congela_out=1, latch display<=dado_out, load the counter with OUT_CICLOS-1, go to OUT_CONTA.
  - If both are 1, IN has priority.
- IN_ESPERA_PRESS: aguardando_in=1. On botao_estavel=1, capture dado_in<={0, chaves} and go to IN_ESPERA_SOLTA.
- IN_ESPERA_SOLTA: aguardando_in=1. On botao_estavel=0, go to IN_FIM.
  - One IN instruction consumes exactly one press and release. A held button cannot satisfy back-to-back INs.
- IN_FIM: in_valido=1 and congela=0 for exactly one cycle. Next state is always OCIOSO.
- OUT_CONTA: decrement the counter. At 0, go to OUT_FIM.
  - With OUT_CICLOS=N, congela is high for N+1 cycles including the OCIOSO cycle.
- OUT_FIM: congela=0 for one cycle, then OCIOSO.
- display holds its value until the next OUT latch. It is never cleared except by reset.
- Abort: if congela_in (respectively congela_out) drops while in an IN (respectively OUT) state other than *_FIM, go to OCIOSO next cycle.
  - In that case there is no in_valido pulse and dado_in is unchanged. display keeps any value already latched.
- Reset mid-operation: the FSM returns to OCIOSO immediately. congela re-asserts as soon as the decoder still presents IN or OUT, and the handshake restarts.
- Counter width: clog2(max(DEBOUNCE_CICLOS, OUT_CICLOS))+1 bits. There is no wrap; it saturates at the load value.

Decomposition:
- Shared package: state encoding constants (3-bit localparams), plus the opcode constants for IN (6'b010000) and OUT (6'b010001) so the decoder and this block use the same values.
- One sub-module: debounce_botao (synchronizer plus stable counter; parameter DEBOUNCE_CICLOS; ports clock, reset, botao, botao_estavel).

Test Plan (DEBOUNCE_CICLOS=4, OUT_CICLOS=8):
- IN, clean press: congela_in=1, chaves=16'h00A5, button held 10 cycles then released.
  - congela=1 throughout, aguardando_in=1.
  - in_valido pulses once about 6 cycles after release, with dado_in=32'h000000A5 and congela=0 on that cycle.
- IN, bounce: button toggles every 2 cycles for 12 cycles.
  - No transition out of IN_ESPERA_PRESS and no capture.
  - A subsequent clean press yields exactly one in_valido.
- OUT: congela_out=1, dado_out=32'hDEADBEEF.
  - display=32'hDEADBEEF one cycle later.
  - congela high 9 cycles, then low 1 cycle, then the FSM returns to OCIOSO.
- Back-to-back IN with the button held through both: first IN completes after release; second IN stays stalled until a fresh press and release.
- Reset asserted in IN_ESPERA_SOLTA: dado_in=0, display=0, no in_valido.
  - After reset release with congela_in=1, congela=1 and the FSM is in IN_ESPERA_PRESS.
- congela_in and congela_out both high: IN path taken, display unchanged.

Source files
------------

// File: rtl/controle_entrada_saida_pkg.sv
// Shared definitions for the I/O stall controller: FSM encoding, I/O opcodes
// and the counter width helper.
package controle_entrada_saida_pkg;

    // 3-bit state encoding
    localparam logic [2:0] EST_OCIOSO          = 3'd0;
    localparam logic [2:0] EST_IN_ESPERA_PRESS = 3'd1;
    localparam logic [2:0] EST_IN_ESPERA_SOLTA = 3'd2;
    localparam logic [2:0] EST_IN_FIM          = 3'd3;
    localparam logic [2:0] EST_OUT_CONTA       = 3'd4;
    localparam logic [2:0] EST_OUT_FIM         = 3'd5;

    typedef enum logic [2:0] {
        OCIOSO          = EST_OCIOSO,
        IN_ESPERA_PRESS = EST_IN_ESPERA_PRESS,
        IN_ESPERA_SOLTA = EST_IN_ESPERA_SOLTA,
        IN_FIM          = EST_IN_FIM,
        OUT_CONTA       = EST_OUT_CONTA,
        OUT_FIM         = EST_OUT_FIM
    } estado_t;

    // Opcodes shared with the instruction decoder
    localparam logic [5:0] OPCODE_IN  = 6'b010000;
    localparam logic [5:0] OPCODE_OUT = 6'b010001;

    // Counter width able to hold the larger of two load values
    function automatic int unsigned largura_contador(input int unsigned a,
                                                     input int unsigned b);
        return $clog2((a > b) ? a : b) + 1;
    endfunction

endpackage

// File: rtl/controle_entrada_saida_debounce.sv
// debounce_botao: 2-flop synchronizer followed by a stability counter.
// Ports: clock, reset (async, active-high), botao (raw button),
//        botao_estavel (debounced level).
module debounce_botao
    import controle_entrada_saida_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CICLOS = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic botao,
    output logic botao_estavel
);

    localparam int unsigned LARG_CONT = largura_contador(DEBOUNCE_CICLOS, 1);
    localparam logic [LARG_CONT-1:0] LIMITE = LARG_CONT'(DEBOUNCE_CICLOS - 1);

    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_estavel;
    logic [LARG_CONT-1:0] r_cont;

    // The count tracks consecutive samples that differ from the accepted level;
    // any sample equal to it restarts the count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_estavel <= 1'b0;
            r_cont    <= '0;
        end else begin
            r_sync1 <= botao;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_estavel) begin
                r_cont <= '0;
            end else if (r_cont == LIMITE) begin
                r_estavel <= r_sync2;
                r_cont    <= '0;
            end else begin
                r_cont <= r_cont + LARG_CONT'(1);
            end
        end
    end

    assign botao_estavel = r_estavel;

endmodule

// File: rtl/controle_entrada_saida.sv
// controle_entrada_saida: stalls the datapath for IN (operator confirm via
// debounced button) and OUT (fixed display hold) instructions.
// Ports: clock/reset; congela_in/congela_out requests from the control unit;
//        chaves, botao, dado_out inputs; congela (combinational stall),
//        dado_in, in_valido, display, aguardando_in registered outputs.
module controle_entrada_saida
    import controle_entrada_saida_pkg::*;
#(
    parameter int unsigned LARGURA_SW      = 16,
    parameter int unsigned DEBOUNCE_CICLOS = 500000,
    parameter int unsigned OUT_CICLOS      = 50000000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  congela_in,
    input  logic                  congela_out,
    input  logic [LARGURA_SW-1:0] chaves,
    input  logic                  botao,
    input  logic [31:0]           dado_out,
    output logic                  congela,
    output logic [31:0]           dado_in,
    output logic                  in_valido,
    output logic [31:0]           display,
    output logic                  aguardando_in
);

    localparam int unsigned LARG_CONT = largura_contador(DEBOUNCE_CICLOS, OUT_CICLOS);
    localparam logic [LARG_CONT-1:0] CARGA_OUT = LARG_CONT'(OUT_CICLOS - 1);

    estado_t              r_estado;
    logic [LARG_CONT-1:0] r_cont;
    logic [31:0]          r_dado_in;
    logic [31:0]          r_display;
    logic                 r_in_valido;
    logic                 r_aguardando;
    logic                 w_botao_estavel;
    logic                 w_libera;

    debounce_botao #(
        .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
    ) u_debounce (
        .clock        (clock),
        .reset        (reset),
        .botao        (botao),
        .botao_estavel(w_botao_estavel)
    );

    // Stall follows the decoder request immediately; released only in the *_FIM states
    assign w_libera = (r_estado == IN_FIM) || (r_estado == OUT_FIM);
    assign congela  = (congela_in | congela_out) & ~w_libera;

    // Handshake FSM with registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado     <= OCIOSO;
            r_cont       <= '0;
            r_dado_in    <= '0;
            r_display    <= '0;
            r_in_valido  <= 1'b0;
            r_aguardando <= 1'b0;
        end else begin
            r_in_valido  <= 1'b0;
            r_aguardando <= 1'b0;
            case (r_estado)
                OCIOSO: begin
                    if (congela_in) begin
                        r_estado     <= IN_ESPERA_PRESS;
                        r_aguardando <= 1'b1;
                    end else if (congela_out) begin
                        r_display <= dado_out;
                        r_cont    <= CARGA_OUT;
                        r_estado  <= OUT_CONTA;
                    end
                end
                IN_ESPERA_PRESS: begin
                    if (!congela_in) begin
                        r_estado <= OCIOSO;
                    end else if (w_botao_estavel) begin
                        r_dado_in    <= 32'(chaves);
                        r_estado     <= IN_ESPERA_SOLTA;
                        r_aguardando <= 1'b1;
                    end else begin
                        r_aguardando <= 1'b1;
                    end
                end
                IN_ESPERA_SOLTA: begin
                    // Completion requires the release, so one press serves one IN
                    if (!congela_in) begin
                        r_estado <= OCIOSO;
                    end else if (!w_botao_estavel) begin
                        r_estado    <= IN_FIM;
                        r_in_valido <= 1'b1;
                    end else begin
                        r_aguardando <= 1'b1;
                    end
                end
                IN_FIM: begin
                    r_estado <= OCIOSO;
                end
                OUT_CONTA: begin
                    if (!congela_out) begin
                        r_estado <= OCIOSO;
                    end else if (r_cont == '0) begin
                        r_estado <= OUT_FIM;
                    end else begin
                        r_cont <= r_cont - LARG_CONT'(1);
                    end
                end
                OUT_FIM: begin
                    r_estado <= OCIOSO;
                end
                default: begin
                    r_estado <= OCIOSO;
                end
            endcase
        end
    end

    assign dado_in       = r_dado_in;
    assign in_valido     = r_in_valido;
    assign display       = r_display;
    assign aguardando_in = r_aguardando;

endmodule

// File: tb/tb_controle_entrada_saida.sv
// Scoreboard bench for controle_entrada_saida with small debounce/display times.
module tb_controle_entrada_saida;

    localparam int unsigned SW = 16;
    localparam int unsigned D  = 4;
    localparam int unsigned O  = 8;

    logic          clock;
    logic          reset;
    logic          congela_in;
    logic          congela_out;
    logic [SW-1:0] chaves;
    logic          botao;
    logic [31:0]   dado_out;
    logic          congela;
    logic [31:0]   dado_in;
    logic          in_valido;
    logic [31:0]   display;
    logic          aguardando_in;

    controle_entrada_saida #(
        .LARGURA_SW     (SW),
        .DEBOUNCE_CICLOS(D),
        .OUT_CICLOS     (O)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .congela_in   (congela_in),
        .congela_out  (congela_out),
        .chaves       (chaves),
        .botao        (botao),
        .dado_out     (dado_out),
        .congela      (congela),
        .dado_in      (dado_in),
        .in_valido    (in_valido),
        .display      (display),
        .aguardando_in(aguardando_in)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected completion of one handshake
    typedef struct {
        bit          e_out;
        logic [31:0] valor;
        int          stall;
    } esperado_t;

    esperado_t   fila[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] modelo_display = '0;
    logic [31:0] modelo_dado_in = '0;

    task automatic chk(input string nome, input logic [31:0] obtido, input logic [31:0] req);
        total++;
        if (obtido !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nome, obtido, req, $time);
        end
    endtask

    task automatic ciclo(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Wait for the stall to drop, then move just past the next edge
    task automatic espera_libera(input string nome);
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (!congela) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: stall never released within 200 cycles", nome);
        end
        ciclo(1);
    endtask

    task automatic pressiona(input int segura);
        botao = 1'b1;
        ciclo(segura);
        botao = 1'b0;
    endtask

    // Toggle every 2 cycles: never D consecutive equal samples
    task automatic trepida();
        for (int i = 0; i < 6; i++) begin
            botao = ~botao;
            ciclo(2);
        end
    endtask

    task automatic transacao_in(input logic [SW-1:0] valor, input bit com_trepidacao,
                                input int segura);
        congela_in = 1'b1;
        chaves     = valor;
        ciclo(1);
        @(negedge clock);
        chk("in_aguardando", 32'(aguardando_in), 32'd1);
        chk("in_congela", 32'(congela), 32'd1);
        ciclo(1);
        if (com_trepidacao) begin
            chaves = ~valor;
            trepida();
            ciclo(8);
            @(negedge clock);
            chk("trepida_aguardando", 32'(aguardando_in), 32'd1);
            chk("trepida_sem_captura", dado_in, modelo_dado_in);
            ciclo(1);
            chaves = valor;
        end
        fila.push_back('{e_out: 1'b0, valor: 32'(valor), stall: -1});
        pressiona(segura);
        espera_libera("in_libera");
        congela_in     = 1'b0;
        modelo_dado_in = 32'(valor);
        ciclo(1);
    endtask

    task automatic transacao_out(input logic [31:0] valor);
        dado_out    = valor;
        congela_out = 1'b1;
        fila.push_back('{e_out: 1'b1, valor: valor, stall: int'(O) + 1});
        @(negedge clock);
        @(negedge clock);
        chk("out_display_1ciclo", display, valor);
        chk("out_sem_aguardando", 32'(aguardando_in), 32'd0);
        espera_libera("out_libera");
        congela_out    = 1'b0;
        dado_out       = $urandom;
        modelo_display = valor;
        ciclo(2);
        chk("out_display_mantido", display, valor);
    endtask

    // Monitor: every stall release or in_valido pulse consumes one expectation
    initial begin
        int        run;
        bit        libera;
        esperado_t e;
        run = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                run = 0;
            end else begin
                libera = (congela_in | congela_out) && !congela;
                if (libera || in_valido) begin
                    if (fila.size() == 0) begin
                        chk("evento_inesperado", 32'(fila.size()), 32'd1);
                    end else begin
                        e = fila.pop_front();
                        if (e.e_out) begin
                            chk("out_in_valido", 32'(in_valido), 32'd0);
                            chk("out_display", display, e.valor);
                            chk("out_ciclos_congela", 32'(run), 32'(e.stall));
                        end else begin
                            chk("in_valido", 32'(in_valido), 32'd1);
                            chk("in_dado", dado_in, e.valor);
                            chk("in_congela_livre", 32'(congela), 32'd0);
                        end
                    end
                    run = 0;
                end else if (congela) begin
                    run++;
                end else begin
                    run = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        reset       = 1'b1;
        congela_in  = 1'b0;
        congela_out = 1'b0;
        chaves      = '0;
        botao       = 1'b0;
        dado_out    = '0;
        ciclo(2);
        @(negedge clock);
        chk("rst_dado_in", dado_in, 32'd0);
        chk("rst_display", display, 32'd0);
        chk("rst_in_valido", 32'(in_valido), 32'd0);
        chk("rst_aguardando", 32'(aguardando_in), 32'd0);
        chk("rst_congela", 32'(congela), 32'd0);
        ciclo(1);
        reset = 1'b0;
        ciclo(2);

        // Clean press, bounced press, OUT
        transacao_in(16'h00A5, 1'b0, 10);
        transacao_in(16'h3C3C, 1'b1, 8);
        transacao_out(32'hDEADBEEF);

        // Back-to-back IN: second one needs a fresh press
        congela_in = 1'b1;
        chaves     = 16'h1234;
        fila.push_back('{e_out: 1'b0, valor: 32'h1234, stall: -1});
        pressiona(10);
        espera_libera("b2b_primeiro");
        modelo_dado_in = 32'h1234;
        chaves = 16'h5678;
        ciclo(15);
        @(negedge clock);
        chk("b2b_aguardando", 32'(aguardando_in), 32'd1);
        chk("b2b_congela", 32'(congela), 32'd1);
        chk("b2b_dado_mantido", dado_in, modelo_dado_in);
        ciclo(1);
        fila.push_back('{e_out: 1'b0, valor: 32'h5678, stall: -1});
        pressiona(8);
        espera_libera("b2b_segundo");
        congela_in     = 1'b0;
        modelo_dado_in = 32'h5678;
        ciclo(2);

        // Reset while waiting for release
        congela_in = 1'b1;
        chaves     = 16'h0BAD;
        botao      = 1'b1;
        ciclo(14);
        reset = 1'b1;
        botao = 1'b0;
        @(negedge clock);
        chk("rst_meio_dado_in", dado_in, 32'd0);
        chk("rst_meio_display", display, 32'd0);
        chk("rst_meio_in_valido", 32'(in_valido), 32'd0);
        modelo_dado_in = '0;
        modelo_display = '0;
        ciclo(2);
        reset = 1'b0;
        ciclo(1);
        @(negedge clock);
        chk("pos_rst_congela", 32'(congela), 32'd1);
        chk("pos_rst_aguardando", 32'(aguardando_in), 32'd1);
        ciclo(1);
        fila.push_back('{e_out: 1'b0, valor: 32'h0BAD, stall: -1});
        pressiona(6);
        espera_libera("pos_rst_in");
        congela_in     = 1'b0;
        modelo_dado_in = 32'h0BAD;
        ciclo(2);

        // Both requests: IN wins, display untouched
        transacao_out(32'h0F0F1234);
        v           = $urandom;
        dado_out    = v;
        congela_out = 1'b1;
        congela_in  = 1'b1;
        chaves      = 16'hBEEF;
        fila.push_back('{e_out: 1'b0, valor: 32'hBEEF, stall: -1});
        ciclo(2);
        pressiona(7);
        espera_libera("ambos");
        congela_in     = 1'b0;
        congela_out    = 1'b0;
        modelo_dado_in = 32'hBEEF;
        ciclo(2);
        chk("ambos_display", display, modelo_display);

        // Abort IN before any press; a later idle press must do nothing
        congela_in = 1'b1;
        ciclo(3);
        congela_in = 1'b0;
        ciclo(2);
        @(negedge clock);
        chk("abort_in_aguardando", 32'(aguardando_in), 32'd0);
        chk("abort_in_dado", dado_in, modelo_dado_in);
        ciclo(1);
        pressiona(8);
        ciclo(10);

        // Abort OUT: latched value stays on the display
        v           = $urandom;
        dado_out    = v;
        congela_out = 1'b1;
        ciclo(3);
        congela_out = 1'b0;
        modelo_display = v;
        ciclo(1);
        @(negedge clock);
        chk("abort_out_display", display, modelo_display);
        chk("abort_out_congela", 32'(congela), 32'd0);
        ciclo(1);

        // Randomized mix
        for (int k = 0; k < 16; k++) begin
            if ($urandom_range(1, 0) == 0)
                transacao_in(SW'($urandom), $urandom_range(2, 0) == 0, int'($urandom_range(12, 6)));
            else
                transacao_out($urandom);
            ciclo(int'($urandom_range(3, 1)));
        end

        ciclo(5);
        chk("fila_vazia", 32'(fila.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
